// File: rtl/flappy_game.sv
// Flappy Bird game-logic core, stepped once per 50 Hz game tick.
// Optional build macro PAUSE_EN adds a pause input that freezes PLAY.
//
// state | meaning
// IDLE  | bird parked at start position, waiting for a flap edge
// PLAY  | physics, scrolling pillars, collision and scoring active
// OVER  | everything frozen until a flap edge returns to IDLE
module flappy_game #(
   parameter int SPEED    = 2,
   parameter int PILLAR_W = 40,
   parameter int GAP      = 120,
   parameter int BIRD_X   = 160,
   parameter int BIRD_SZ  = 16,
   parameter int FLAP_VEL = 8,
   parameter int VMAX     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flap,
`ifdef PAUSE_EN
   input  logic       pause,
`endif
   output logic [9:0] y,
   output logic [8:0] p1,
   output logic [8:0] p2,
   output logic [9:0] x1,
   output logic [9:0] x2,
   output logic [1:0] state,
   output logic [9:0] score,
   output logic [9:0] high_score
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;

   localparam logic [9:0] Y_RST     = 10'd232;
   localparam logic [9:0] Y_MAX     = 10'd464;
   localparam logic [9:0] X1_RST    = 10'd680;
   localparam logic [9:0] X2_RST    = 10'd1020;
   localparam logic [9:0] X_WRAP    = 10'd680;
   localparam logic [8:0] P_RST     = 9'd160;
   localparam logic [8:0] P_BASE    = 9'd40;
   localparam logic [9:0] SCORE_MAX = 10'd999;
   localparam logic [7:0] LFSR_RST  = 8'hA5;

   localparam logic [9:0]        BX     = 10'(BIRD_X);
   localparam logic [9:0]        X_HI   = 10'(BIRD_X + BIRD_SZ + PILLAR_W);
   localparam logic [9:0]        SPD    = 10'(SPEED);
   localparam logic [10:0]       BSZ11  = 11'(BIRD_SZ);
   localparam logic [10:0]       GAP11  = 11'(GAP);
   localparam logic signed [5:0] V_KICK = 6'(-FLAP_VEL);
   localparam logic signed [5:0] V_MAX  = 6'(VMAX);

   state_t            state_q, state_d;
   logic [9:0]        y_q, y_d, x1_q, x1_d, x2_q, x2_d;
   logic [8:0]        p1_q, p1_d, p2_q, p2_d;
   logic [9:0]        score_q, score_d, high_q, high_d;
   logic signed [5:0] vel_q, vel_d;
   logic [7:0]        lfsr_q, lfsr_d;
   logic              flap_q, flap_d;

   logic              fe, paused, hit1, hit2, wrap1, wrap2, cross1, cross2;
   logic signed [11:0] y_sum;
   logic [9:0]        score_sum;

   function automatic logic pillar_hit(input logic [9:0] x, input logic [8:0] p,
                                       input logic [9:0] yy);
      logic [10:0] ys, top;
      ys  = {1'b0, yy};
      top = {2'b00, p};
      return (x > BX) && (x < X_HI) && ((ys < top) || (ys + BSZ11 > top + GAP11));
   endfunction

`ifdef PAUSE_EN
   assign paused = pause;
`else
   assign paused = 1'b0;
`endif

   always_comb begin
      fe        = flap & ~flap_q;
      flap_d    = flap;
      lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      state_d   = state_q;
      y_d       = y_q;
      vel_d     = vel_q;
      x1_d      = x1_q;
      x2_d      = x2_q;
      p1_d      = p1_q;
      p2_d      = p2_q;
      score_d   = score_q;
      high_d    = high_q;
      hit1      = pillar_hit(x1_q, p1_q, y_q);
      hit2      = pillar_hit(x2_q, p2_q, y_q);
      y_sum     = $signed({2'b00, y_q}) + $signed({{6{vel_q[5]}}, vel_q});
      wrap1     = x1_q < SPD;
      wrap2     = x2_q < SPD;
      cross1    = 1'b0;
      cross2    = 1'b0;
      score_sum = score_q;

      case (state_q)
         S_IDLE: begin
            if (fe) begin
               state_d = S_PLAY;
               vel_d   = V_KICK;
            end
         end
         S_PLAY: begin
            if (!paused) begin
               if (hit1 || hit2) begin
                  state_d = S_OVER;
               end else begin
                  if (fe)
                     vel_d = V_KICK;
                  else if (vel_q >= V_MAX)
                     vel_d = V_MAX;
                  else
                     vel_d = vel_q + 6'sd1;

                  // Hitting the ceiling is harmless; reaching the ground ends the game.
                  if (y_sum < 12'sd0) begin
                     y_d = 10'd0;
                  end else if (y_sum >= $signed({2'b00, Y_MAX})) begin
                     y_d     = Y_MAX;
                     state_d = S_OVER;
                  end else begin
                     y_d = y_sum[9:0];
                  end

                  x1_d = wrap1 ? X_WRAP : x1_q - SPD;
                  x2_d = wrap2 ? X_WRAP : x2_q - SPD;
                  if (wrap1) p1_d = P_BASE + {1'b0, lfsr_q};
                  if (wrap2) p2_d = P_BASE + {1'b0, lfsr_q};

                  cross1    = (x1_q > BX) && (x1_d <= BX);
                  cross2    = (x2_q > BX) && (x2_d <= BX);
                  score_sum = score_q + {9'd0, cross1} + {9'd0, cross2};
                  score_d   = (score_sum > SCORE_MAX) ? SCORE_MAX : score_sum;
               end
               if (state_d == S_OVER && score_d > high_q)
                  high_d = score_d;
            end
         end
         S_OVER: begin
            if (fe) begin
               state_d = S_IDLE;
               y_d     = Y_RST;
               vel_d   = 6'sd0;
               x1_d    = X1_RST;
               x2_d    = X2_RST;
               p1_d    = P_RST;
               p2_d    = P_RST;
               score_d = 10'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         y_q     <= Y_RST;
         vel_q   <= 6'sd0;
         x1_q    <= X1_RST;
         x2_q    <= X2_RST;
         p1_q    <= P_RST;
         p2_q    <= P_RST;
         score_q <= 10'd0;
         high_q  <= 10'd0;
         lfsr_q  <= LFSR_RST;
         flap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         vel_q   <= vel_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         score_q <= score_d;
         high_q  <= high_d;
         lfsr_q  <= lfsr_d;
         flap_q  <= flap_d;
      end
   end

   assign y          = y_q;
   assign p1         = p1_q;
   assign p2         = p2_q;
   assign x1         = x1_q;
   assign x2         = x2_q;
   assign state      = state_q;
   assign score      = score_q;
   assign high_score = high_q;

endmodule

// File: tb/tb_flappy_game.sv
// Directed self-checking bench for flappy_game; expected values worked out by hand
// from the bird kinematics (y after k free ticks from a kick = 232 - 8k + k(k-1)/2).
module tb_flappy_game;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flap = 1'b0;
`ifdef PAUSE_EN
   logic       pause = 1'b0;
`endif
   logic [9:0] y, x1, x2, score, high_score;
   logic [8:0] p1, p2;
   logic [1:0] state;

   int vecs = 0;
   int errs = 0;

   flappy_game dut (
      .clk        (clk),
      .rst        (rst),
      .flap       (flap),
`ifdef PAUSE_EN
      .pause      (pause),
`endif
      .y          (y),
      .p1         (p1),
      .p2         (p2),
      .x1         (x1),
      .x2         (x2),
      .state      (state),
      .score      (score),
      .high_score (high_score)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst  = 1'b1;
      flap = 1'b0;
      tick();
      rst  = 1'b0;
   endtask

   function automatic logic [7:0] lstep(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   task automatic test_reset;
      do_reset();
      repeat (5) tick();
      vecs++; if (y !== 10'd232) begin errs++; $display("FAIL reset_y got %0d want 232", y); end
      vecs++; if (x1 !== 10'd680) begin errs++; $display("FAIL reset_x1 got %0d want 680", x1); end
      vecs++; if (x2 !== 10'd1020) begin errs++; $display("FAIL reset_x2 got %0d want 1020", x2); end
      vecs++; if (p1 !== 9'd160 || p2 !== 9'd160) begin errs++; $display("FAIL reset_p got %0d/%0d want 160/160", p1, p2); end
      vecs++; if (state !== 2'd0) begin errs++; $display("FAIL reset_state got %0d want 0", state); end
      vecs++; if (score !== 10'd0 || high_score !== 10'd0) begin errs++; $display("FAIL reset_score got %0d/%0d want 0/0", score, high_score); end
   endtask

   task automatic test_flap_start;
      flap = 1'b1;
      tick();
      vecs++; if (state !== 2'd1) begin errs++; $display("FAIL start_state got %0d want 1", state); end
      vecs++; if (y !== 10'd232) begin errs++; $display("FAIL start_y0 got %0d want 232", y); end
      flap = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         case (n)
            1: begin
               vecs++; if (y !== 10'd224) begin errs++; $display("FAIL start_y1 got %0d want 224", y); end
               vecs++; if (x1 !== 10'd678) begin errs++; $display("FAIL start_x1 got %0d want 678", x1); end
            end
            8:  begin vecs++; if (y !== 10'd196) begin errs++; $display("FAIL apex_y got %0d want 196", y); end end
            16: begin vecs++; if (y !== 10'd224) begin errs++; $display("FAIL fall_y16 got %0d want 224", y); end end
            17: begin vecs++; if (y !== 10'd232) begin errs++; $display("FAIL vmax_y17 got %0d want 232", y); end end
            18: begin vecs++; if (y !== 10'd240) begin errs++; $display("FAIL vmax_y18 got %0d want 240", y); end end
            20: begin
               vecs++; if (y !== 10'd256) begin errs++; $display("FAIL vmax_y20 got %0d want 256", y); end
               vecs++; if (x1 !== 10'd640 || x2 !== 10'd980) begin errs++; $display("FAIL scroll20 got %0d/%0d want 640/980", x1, x2); end
               vecs++; if (state !== 2'd1) begin errs++; $display("FAIL play20_state got %0d want 1", state); end
            end
            default: ;
         endcase
      end
   endtask

   task automatic test_ground;
      for (int n = 21; n <= 46; n++) begin
         tick();
         if (n == 45) begin
            vecs++; if (y !== 10'd456 || state !== 2'd1) begin errs++; $display("FAIL preground got y=%0d st=%0d want 456/1", y, state); end
         end
      end
      vecs++; if (y !== 10'd464 || state !== 2'd2) begin errs++; $display("FAIL ground got y=%0d st=%0d want 464/2", y, state); end
      vecs++; if (x1 !== 10'd588 || x2 !== 10'd928) begin errs++; $display("FAIL ground_x got %0d/%0d want 588/928", x1, x2); end
      vecs++; if (score !== 10'd0 || high_score !== 10'd0) begin errs++; $display("FAIL ground_score got %0d/%0d want 0/0", score, high_score); end
      for (int k = 0; k < 10; k++) begin
         tick();
         vecs++;
         if (y !== 10'd464 || x1 !== 10'd588 || state !== 2'd2) begin
            errs++; $display("FAIL over_frozen got y=%0d x1=%0d st=%0d want 464/588/2", y, x1, state);
         end
      end
   endtask

   task automatic test_over_to_idle;
      flap = 1'b1;
      tick();
      vecs++; if (state !== 2'd0) begin errs++; $display("FAIL restart_state got %0d want 0", state); end
      vecs++; if (y !== 10'd232 || x1 !== 10'd680 || x2 !== 10'd1020) begin errs++; $display("FAIL restart_pos got %0d/%0d/%0d want 232/680/1020", y, x1, x2); end
      vecs++; if (score !== 10'd0) begin errs++; $display("FAIL restart_score got %0d want 0", score); end
   endtask

   task automatic test_flap_hold;
      tick();
      vecs++; if (state !== 2'd0) begin errs++; $display("FAIL held_no_edge got %0d want 0", state); end
      flap = 1'b0;
      tick();
      flap = 1'b1;
      repeat (10) tick();
      vecs++; if (state !== 2'd1) begin errs++; $display("FAIL hold_state got %0d want 1", state); end
      vecs++; if (y !== 10'd196) begin errs++; $display("FAIL hold_one_kick got %0d want 196", y); end
      flap = 1'b0;
   endtask

   task automatic test_clamp;
      do_reset();
      flap = 1'b1;
      tick();
      for (int n = 1; n <= 32; n++) begin
         flap = (n % 2 == 0);
         tick();
         if (n == 30) begin vecs++; if (y !== 10'd7) begin errs++; $display("FAIL clamp_y30 got %0d want 7", y); end end
         if (n == 31) begin vecs++; if (y !== 10'd0) begin errs++; $display("FAIL clamp_y31 got %0d want 0", y); end end
      end
      vecs++; if (y !== 10'd0 || state !== 2'd1) begin errs++; $display("FAIL clamp_y32 got y=%0d st=%0d want 0/1", y, state); end
      flap = 1'b0;
   endtask

   task automatic test_collision;
      do_reset();
      flap = 1'b1;
      tick();
      for (int n = 1; n <= 234; n++) begin
         flap = (n <= 220) && (n % 17 == 0);
         tick();
         if (n == 233) begin
            vecs++; if (state !== 2'd1 || y !== 10'd328 || x1 !== 10'd214) begin errs++; $display("FAIL prehit got st=%0d y=%0d x1=%0d want 1/328/214", state, y, x1); end
         end
      end
      vecs++; if (state !== 2'd2) begin errs++; $display("FAIL hit_state got %0d want 2", state); end
      vecs++; if (y !== 10'd328 || x1 !== 10'd214 || x2 !== 10'd554) begin errs++; $display("FAIL hit_frozen got y=%0d x1=%0d x2=%0d want 328/214/554", y, x1, x2); end
      flap = 1'b0;
   endtask

   task automatic test_score;
      logic [7:0] l;
      logic       reached;
      l = 8'hA5;
      for (int k = 0; k < 341; k++) l = lstep(l);
      do_reset();
      flap = 1'b1;
      tick();
      for (int n = 1; n <= 430; n++) begin
         flap = (n % 17 == 0);
         tick();
         case (n)
            259: begin vecs++; if (score !== 10'd0 || x1 !== 10'd162) begin errs++; $display("FAIL score_pre got %0d x1=%0d want 0/162", score, x1); end end
            260: begin vecs++; if (score !== 10'd1 || x1 !== 10'd160) begin errs++; $display("FAIL score_cross1 got %0d x1=%0d want 1/160", score, x1); end end
            340: begin vecs++; if (x1 !== 10'd0) begin errs++; $display("FAIL x1_low got %0d want 0", x1); end end
            341: begin
               vecs++; if (x1 !== 10'd680 || state !== 2'd1) begin errs++; $display("FAIL x1_wrap got %0d st=%0d want 680/1", x1, state); end
               vecs++; if (p1 < 9'd40 || p1 > 9'd295) begin errs++; $display("FAIL p1_range got %0d want 40..295", p1); end
               vecs++; if (p1 !== 9'd40 + {1'b0, l}) begin errs++; $display("FAIL p1_lfsr got %0d want %0d", p1, 9'd40 + {1'b0, l}); end
            end
            429: begin vecs++; if (score !== 10'd1) begin errs++; $display("FAIL score_pre2 got %0d want 1", score); end end
            430: begin vecs++; if (score !== 10'd2 || x2 !== 10'd160) begin errs++; $display("FAIL score_cross2 got %0d x2=%0d want 2/160", score, x2); end end
            default: ;
         endcase
      end
      flap = 1'b0;
      reached = 1'b0;
      for (int k = 0; k < 100 && !reached; k++) begin
         tick();
         if (state == 2'd2) reached = 1'b1;
      end
      vecs++; if (state !== 2'd2) begin errs++; $display("FAIL fall_timeout got st=%0d want 2", state); end
      vecs++; if (score !== 10'd2 || high_score !== 10'd2) begin errs++; $display("FAIL over_high got %0d/%0d want 2/2", score, high_score); end
      flap = 1'b1;
      tick();
      flap = 1'b0;
      vecs++; if (state !== 2'd0 || score !== 10'd0 || high_score !== 10'd2) begin errs++; $display("FAIL idle_keep_high got st=%0d %0d/%0d want 0 0/2", state, score, high_score); end
      vecs++; if (y !== 10'd232 || x1 !== 10'd680 || p1 !== 9'd160) begin errs++; $display("FAIL idle_reload got %0d/%0d/%0d want 232/680/160", y, x1, p1); end
      do_reset();
      vecs++; if (high_score !== 10'd0 || state !== 2'd0) begin errs++; $display("FAIL rst_high got %0d st=%0d want 0/0", high_score, state); end
   endtask

`ifdef PAUSE_EN
   task automatic test_pause;
      do_reset();
      flap = 1'b1;
      tick();
      flap = 1'b0;
      tick();
      pause = 1'b1;
      flap  = 1'b1;
      tick();
      flap = 1'b0;
      repeat (2) tick();
      vecs++; if (y !== 10'd224 || x1 !== 10'd678 || state !== 2'd1) begin errs++; $display("FAIL pause_hold got y=%0d x1=%0d st=%0d want 224/678/1", y, x1, state); end
      pause = 1'b0;
      tick();
      vecs++; if (y !== 10'd217 || x1 !== 10'd676) begin errs++; $display("FAIL pause_resume got y=%0d x1=%0d want 217/676", y, x1); end
   endtask
`endif

   initial begin
      test_reset();
      test_flap_start();
      test_ground();
      test_over_to_idle();
      test_flap_hold();
      test_clamp();
      test_collision();
      test_score();
`ifdef PAUSE_EN
      test_pause();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
